// File: rtl/led_fade_pwm_if.sv
// Control/status bundle between the blink generator side and the LED fade stage.
interface led_fade_pwm_if #(
    parameter int PWM_W = 8
);
    logic             en;
    logic             led_in;
    logic             led_out;
    logic [PWM_W-1:0] level;
    logic             busy;

    modport master (
        output en,
        output led_in,
        input  led_out,
        input  level,
        input  busy
    );

    modport slave (
        input  en,
        input  led_in,
        output led_out,
        output level,
        output busy
    );
endinterface

// File: rtl/led_fade_pwm.sv
// Turns LED level changes into linear brightness fades rendered with a free-running PWM.
// Optional build macro LED_FADE_GAMMA_EN applies a square-law brightness-to-duty curve.
module led_fade_pwm #(
    parameter int PWM_W       = 8,
    parameter int STEP_CYCLES = 50000
) (
    input  logic            clk,
    input  logic            rst,
    led_fade_pwm_if.slave   bus
);
    localparam logic [PWM_W-1:0] MAX      = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] ZERO     = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] ONE      = PWM_W'(1'b1);
    localparam int               STEP_W   = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_ZERO = {STEP_W{1'b0}};
    localparam logic [STEP_W-1:0] STEP_ONE  = STEP_W'(1'b1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_UP   = 2'd1,
        ST_ON   = 2'd2,
        ST_DOWN = 2'd3
    } state_t;

    state_t            state_q;
    logic [PWM_W-1:0]  level_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic              busy_q;
    logic [PWM_W-1:0]  pwm_cnt_q;
    logic [PWM_W-1:0]  duty_r_q;
    logic              led_out_q;
    logic              led_out_d;
    logic [PWM_W-1:0]  duty_s;
    logic              step_tick_s;

    // Brightness-to-duty mapping; full scale always stays fully on.
    function automatic logic [PWM_W-1:0] duty_of(input logic [PWM_W-1:0] lvl);
`ifdef LED_FADE_GAMMA_EN
        logic [2*PWM_W-1:0] prod;
        prod = {ZERO, lvl} * {ZERO, lvl};
        if (lvl == MAX) begin
            return MAX;
        end else begin
            return prod[2*PWM_W-1:PWM_W];
        end
`else
        return lvl;
`endif
    endfunction

    assign step_tick_s = (step_cnt_q == STEP_LAST);
    assign duty_s      = duty_of(level_q);

    // PWM compare with the saturated endpoints forced to constant levels.
    always_comb begin
        led_out_d = 1'b0;
        if (duty_r_q == MAX) begin
            led_out_d = 1'b1;
        end else if (duty_r_q == ZERO) begin
            led_out_d = 1'b0;
        end else begin
            led_out_d = (pwm_cnt_q < duty_r_q);
        end
    end

    // Free-running PWM period; duty is latched only at the period boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= ZERO;
            duty_r_q  <= ZERO;
            led_out_q <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + ONE;
            led_out_q <= led_out_d;
            if (pwm_cnt_q == MAX) begin
                duty_r_q <= duty_s;
            end
        end
    end

    // Fade FSM: a reversal restarts the step timer without moving the level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_OFF;
            level_q    <= ZERO;
            step_cnt_q <= STEP_ZERO;
            busy_q     <= 1'b0;
        end else if (bus.en) begin
            case (state_q)
                ST_OFF: begin
                    step_cnt_q <= STEP_ZERO;
                    if (bus.led_in) begin
                        state_q <= ST_UP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_UP: begin
                    if (!bus.led_in) begin
                        state_q    <= ST_DOWN;
                        step_cnt_q <= STEP_ZERO;
                    end else if (step_tick_s) begin
                        step_cnt_q <= STEP_ZERO;
                        if (level_q >= MAX - ONE) begin
                            level_q <= MAX;
                            state_q <= ST_ON;
                            busy_q  <= 1'b0;
                        end else begin
                            level_q <= level_q + ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_ONE;
                    end
                end
                ST_ON: begin
                    step_cnt_q <= STEP_ZERO;
                    if (!bus.led_in) begin
                        state_q <= ST_DOWN;
                        busy_q  <= 1'b1;
                    end
                end
                ST_DOWN: begin
                    if (bus.led_in) begin
                        state_q    <= ST_UP;
                        step_cnt_q <= STEP_ZERO;
                    end else if (step_tick_s) begin
                        step_cnt_q <= STEP_ZERO;
                        if (level_q <= ONE) begin
                            level_q <= ZERO;
                            state_q <= ST_OFF;
                            busy_q  <= 1'b0;
                        end else begin
                            level_q <= level_q - ONE;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + STEP_ONE;
                    end
                end
                default: begin
                    state_q    <= ST_OFF;
                    level_q    <= ZERO;
                    step_cnt_q <= STEP_ZERO;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led_out = led_out_q;
    assign bus.level   = level_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_led_fade_pwm.sv
// Randomized bench for led_fade_pwm against a direction/tick-count brightness model.
module tb_led_fade_pwm;
    localparam int PWM_W = 4;
    localparam int STEP  = 4;
    localparam int MAXL  = (1 << PWM_W) - 1;
    localparam int PER   = 1 << PWM_W;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    led_fade_pwm_if #(.PWM_W(PWM_W)) bus ();

    led_fade_pwm #(.PWM_W(PWM_W), .STEP_CYCLES(STEP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: brightness moves one unit per STEP enabled cycles toward the target.
    int m_level, m_dir, m_ticks, m_pcnt, m_duty, m_led;

    function automatic int model_duty(input int l);
`ifdef LED_FADE_GAMMA_EN
        if (l == MAXL) return MAXL;
        return (l * l) / PER;
`else
        return l;
`endif
    endfunction

    task automatic chk_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_level = 0; m_dir = 0; m_ticks = 0; m_pcnt = 0; m_duty = 0; m_led = 0;
    endtask

    task automatic model_edge();
        int want;
        if (rst) begin
            model_reset();
            return;
        end
        m_led = (m_duty == MAXL) ? 1 : (m_duty == 0) ? 0 : (m_pcnt < m_duty ? 1 : 0);
        if (m_pcnt == MAXL) m_duty = model_duty(m_level);
        m_pcnt = (m_pcnt + 1) % PER;
        if (!bus.en) return;
        want = bus.led_in ? 1 : -1;
        if (m_dir == 0) begin
            if ((want == 1 && m_level < MAXL) || (want == -1 && m_level > 0)) begin
                m_dir = want; m_ticks = 0;
            end
        end else if (want != m_dir) begin
            m_dir = want; m_ticks = 0;
        end else begin
            m_ticks++;
            if (m_ticks == STEP) begin
                m_ticks = 0;
                m_level = m_level + m_dir;
                if (m_level < 0) m_level = 0;
                if (m_level > MAXL) m_level = MAXL;
                if (m_level == 0 || m_level == MAXL) m_dir = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk_eq("led_out", int'(bus.led_out), m_led);
        chk_eq("level", int'(bus.level), m_level);
        chk_eq("busy", int'(bus.busy), (m_dir != 0) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_until_level(input int target, input int budget);
        int b;
        b = budget;
        while (m_level != target && b > 0) begin
            tick();
            b--;
        end
        chk_eq("reach_level", int'(bus.level), target);
    endtask

    task automatic count_high(input string tag, input int exp);
        int h;
        h = 0;
        for (int i = 0; i < PER; i++) begin
            tick();
            h += int'(bus.led_out);
        end
        chk_eq(tag, h, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(3);
        rst = 1'b0;
    endtask

    initial begin
        int max_seen, len;
        n_checks = 0;
        n_pass   = 0;
        model_reset();
        rst = 1'b1;
        bus.en = 1'b1;
        bus.led_in = 1'b1;
        #1;
        chk_eq("rst_led_out", int'(bus.led_out), 0);
        run(10);

        // Full fade up and settle at constant on.
        rst = 1'b0;
        tick();
        chk_eq("busy_first", int'(bus.busy), 1);
        run(60);
        chk_eq("full_level", int'(bus.level), MAXL);
        chk_eq("full_busy", int'(bus.busy), 0);
        run(2 * PER);
        count_high("duty15", PER);

        // Asynchronous clear between edges.
        rst = 1'b1;
        #2;
        chk_eq("async_led_out", int'(bus.led_out), 0);
        chk_eq("async_level", int'(bus.level), 0);
        chk_eq("async_busy", int'(bus.busy), 0);
        model_reset();
        run(2);
        rst = 1'b0;

        // Freeze at level 8 and measure the duty.
        bus.led_in = 1'b1;
        run_until_level(8, 200);
        bus.en = 1'b0;
        run(2 * PER);
`ifdef LED_FADE_GAMMA_EN
        count_high("duty8", 4);
`else
        count_high("duty8", 8);
`endif
        bus.en = 1'b1;

        // Freeze mid-step at 9, then resume.
        run_until_level(9, 100);
        run(2);
        bus.en = 1'b0;
        run(20);
        chk_eq("freeze_level", int'(bus.level), 9);
        chk_eq("freeze_busy", int'(bus.busy), 1);
        bus.en = 1'b1;
        run(8);

        // Reversal at level 5 must not overshoot.
        do_reset();
        bus.led_in = 1'b1;
        run_until_level(5, 200);
        bus.led_in = 1'b0;
        max_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (int'(bus.level) > max_seen) max_seen = int'(bus.level);
        end
        chk_eq("rev_max", max_seen, 5);
        run(2 * PER);
        chk_eq("rev_off_level", int'(bus.level), 0);
        count_high("duty0", 0);

        // Random segments.
        for (int s = 0; s < 120; s++) begin
            bus.led_in = 1'($urandom_range(0, 1));
            bus.en     = ($urandom_range(0, 7) != 0);
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 120)) : int'($urandom_range(1, 40));
            if ($urandom_range(0, 19) == 0) do_reset();
            run(len);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/led_fade_pwm.md
Name: led_fade_pwm

Overview:
- Downstream stage of the LED blink generator: consumes its `led` level and drives the physical LED pin.
- Each level change becomes a linear brightness fade: ramp up on 1, ramp down on 0.
- A free-running PWM counter produces the pin waveform.
- Sits between the blink/toggle logic and the top-level LED output.

Parameters:
PWM_W, 8, width of PWM counter and brightness level (MAX = 2^PWM_W-1)
STEP_CYCLES, 50000, clk cycles per one-LSB brightness step while fading (>=1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
en  input  1  fade enable; 0 freezes the fade FSM and step counter
led_in  input  1  target level from blink generator (clk domain, no synchroniser)
led_out  output  1  PWM drive to LED pin, registered
level  output  PWM_W  current brightness, 0..MAX
busy  output  1  high while fading (RAMP_UP or RAMP_DOWN)

Behaviour:
- Reset (async, rst=1):
  - pwm_cnt=0, step_cnt=0, level=0, duty_r=0, state=OFF.
  - led_out=0, busy=0, applied immediately without a clock edge.
- pwm_cnt:
  - Free-runs 0..MAX and wraps to 0; unaffected by en.
- duty_r:
  - Reloaded from duty only in the cycle pwm_cnt==MAX, so the duty never changes mid-period.
  - Without the optional feature, duty = level.
- led_out (registered, one cycle after compare):
  - duty_r==MAX: constant 1.
  - duty_r==0: constant 0.
  - Otherwise: (pwm_cnt < duty_r).
- step_cnt / step_tick:
  - Counts only in RAMP_UP/RAMP_DOWN with en=1.
  - step_tick = (step_cnt==STEP_CYCLES-1); step_cnt wraps to 0 on step_tick.
  - Cleared to 0 on every state change and in OFF/ON.
- FSM (evaluated only when en=1; en=0 holds state, level, step_cnt):
  - OFF: led_in=1 -> RAMP_UP.
  - RAMP_UP: led_in=0 -> RAMP_DOWN, with no level change that cycle even if step_tick. Else on step_tick level+1; the step that makes level==MAX also moves to ON.
  - ON: led_in=0 -> RAMP_DOWN.
  - RAMP_DOWN: led_in=1 -> RAMP_UP, with no level change that cycle. Else on step_tick level-1; the step that makes level==0 also moves to OFF.
- level saturates at 0 and MAX; it never wraps.
- busy = (state==RAMP_UP || state==RAMP_DOWN), registered with state.
- Full fade 0->MAX takes MAX*STEP_CYCLES cycles (default 255 ms at 50 MHz).
- Reversal mid-fade reverses from the current level; no jump.
- Reset mid-fade returns to OFF/level 0 regardless of led_in; fading restarts on the first clock after rst deasserts if led_in=1.

Optional Feature:
- Macro: LED_FADE_GAMMA_EN.
- Defined: duty = (level*level) >> PWM_W, a perceptual square law, computed with a 2*PWM_W-bit product. level==MAX still maps to duty=MAX (constant on); level==0 maps to 0.
- Undefined: duty = level (linear); no multiplier is synthesised.
- level output and FSM are identical in both builds.

Test Plan (PWM_W=4, STEP_CYCLES=4 unless noted):
1. Reset: rst=1, led_in=1, en=1 held 10 cycles -> led_out=0, level=0, busy=0 throughout; async clear checked by asserting rst between edges.
2. Full fade up: rst released, led_in=1, en=1 -> busy=1 next cycle; level increments every 4 cycles; level=15 at 60 cycles; state ON, busy=0; led_out constant 1 from the first full PWM period after duty_r=15.
3. Duty check: fade stopped at level=8 via en=0 -> led_out high exactly 8 of every 16 cycles, aligned to pwm_cnt 0..7 (+1 cycle latency).
4. Reversal: led_in=1 until level=5, then led_in=0 -> level never exceeds 5; decrements 5,4,...,0 every 4 cycles; state OFF, busy=0; led_out constant 0.
5. Freeze: en=0 for 20 cycles at level=9 mid-RAMP_UP -> level stays 9, busy stays 1, PWM continues at 9/16; after en=1 the next step occurs after the remaining step_cnt count.
6. Gamma (LED_FADE_GAMMA_EN defined): level=8 -> 4/16 high; level=15 -> constant 1; level=3 -> 0/16 (9>>4=0), led_out stays 0.
